// File: rtl/spi_master_ctrl_pkg.sv
// Shared types and constants for the SPI master controller: state and op
// encodings, frame geometry and the {op, payload} frame layout.
package spi_master_ctrl_pkg;

   localparam int unsigned ADDR_SIZE  = 8;
   localparam int unsigned MEM_WIDTH  = 8;
   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned RD_BITS    = 8;
   localparam int unsigned OP_BITS    = 2;
   localparam int unsigned CNT_BITS   = 4;

   typedef enum logic [2:0] {
      M_IDLE    = 3'b000,
      M_CMD     = 3'b001,
      M_SHIFT   = 3'b010,
      M_TURN    = 3'b011,
      M_CAPTURE = 3'b100,
      M_END     = 3'b101
   } mst_state_e;

   typedef enum logic [OP_BITS-1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } op_e;

   typedef struct packed {
      op_e                  op;
      logic [MEM_WIDTH-1:0] payload;
   } frame_t;

   // Read-data frames carry no payload; the field is sent as zeros.
   function automatic frame_t build_frame(input op_e op, input logic [MEM_WIDTH-1:0] payload);
      frame_t f;
      f.op      = op;
      f.payload = (op == OP_RD_DATA) ? '0 : payload;
      return f;
   endfunction

endpackage

// File: rtl/spi_mst_shift_reg.sv
// Load/shift register with serial input, MSB-first shifting.
module spi_mst_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             shift_i,
   input  logic             si_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load_i) begin
         data_d = load_data_i;
      end else if (shift_i) begin
         data_d = {data_q[WIDTH-2:0], si_i};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: turns parallel commands into SS_n/MOSI frames and returns
// the MISO byte of read-data frames on a parallel response port.
module spi_master_ctrl
   import spi_master_ctrl_pkg::*;
#(
   parameter int unsigned TURNAROUND = 2,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [OP_BITS-1:0]   cmd_op,
   input  logic [MEM_WIDTH-1:0] cmd_payload,
   output logic                 SS_n,
   output logic                 MOSI,
   input  logic                 MISO,
   output logic                 rd_valid,
   output logic [RD_BITS-1:0]   rd_data,
   output logic                 busy
);

   mst_state_e            state_q, state_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   op_e                   op_q, op_d;
   logic                  ss_n_q, ss_n_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  busy_q, busy_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  accept_c;
   logic [FRAME_BITS-1:0] tx_data;
   logic [RD_BITS-1:0]    rx_data;
   logic                  unused_tx_bits;

   assign accept_c = cmd_valid && cmd_ready_q;

   // TX frame: loaded on acceptance, its MSB is MOSI. Shifting starts after
   // the first SHIFT cycle so frame[9] appears in both CMD and SHIFT[0], and
   // the register is all-zero again once the frame has been sent.
   spi_mst_shift_reg #(
      .WIDTH (FRAME_BITS)
   ) u_tx_shift (
      .clk         (clk),
      .rst         (rst),
      .load_i      (accept_c),
      .load_data_i (build_frame(op_e'(cmd_op), cmd_payload)),
      .shift_i     (state_q == M_SHIFT),
      .si_i        (1'b0),
      .data_o      (tx_data)
   );

   // RX byte: MISO enters MSB-first on every CAPTURE edge.
   spi_mst_shift_reg #(
      .WIDTH (RD_BITS)
   ) u_rx_shift (
      .clk         (clk),
      .rst         (rst),
      .load_i      (1'b0),
      .load_data_i ('0),
      .shift_i     (state_q == M_CAPTURE),
      .si_i        (MISO),
      .data_o      (rx_data)
   );

   assign unused_tx_bits = ^tx_data[FRAME_BITS-2:0];

   // Next-state logic plus lookahead for the registered outputs.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = '0;
      ss_n_d      = 1'b1;
      cmd_ready_d = 1'b0;
      busy_d      = 1'b0;
      rd_valid_d  = 1'b0;

      unique case (state_q)
         M_IDLE: begin
            if (accept_c) begin
               state_d = M_CMD;
               op_d    = op_e'(cmd_op);
            end
         end
         M_CMD: begin
            state_d = M_SHIFT;
         end
         M_SHIFT: begin
            if (cnt_q == CNT_BITS'(FRAME_BITS - 1)) begin
               state_d = (op_q == OP_RD_DATA) ? M_TURN : M_END;
            end
         end
         M_TURN: begin
            if (cnt_q == CNT_BITS'(TURNAROUND - 1)) begin
               state_d = M_CAPTURE;
            end
         end
         M_CAPTURE: begin
            if (cnt_q == CNT_BITS'(RD_BITS - 1)) begin
               state_d = M_END;
            end
         end
         M_END: begin
            if (cnt_q == CNT_BITS'(GAP_CYCLES - 1)) begin
               state_d = M_IDLE;
            end
         end
         default: begin
            state_d = M_IDLE;
         end
      endcase

      // One counter serves every timed state; it restarts on each transition.
      if ((state_d == state_q) && (state_q != M_IDLE)) begin
         cnt_d = cnt_q + CNT_BITS'(1);
      end

      ss_n_d      = !(state_d inside {M_CMD, M_SHIFT, M_TURN, M_CAPTURE});
      cmd_ready_d = (state_d == M_IDLE);
      busy_d      = (state_d != M_IDLE);
      rd_valid_d  = (state_q == M_CAPTURE) && (state_d == M_END);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= M_IDLE;
         cnt_q       <= '0;
         op_q        <= OP_WR_ADDR;
         ss_n_q      <= 1'b1;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         ss_n_q      <= ss_n_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign SS_n      = ss_n_q;
   assign MOSI      = tx_data[FRAME_BITS-1];
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rx_data;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl with a behavioural SPI RAM slave model.
module tb_spi_master_ctrl;

   localparam int unsigned T = 2;
   localparam int unsigned G = 2;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_payload;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       busy;

   spi_master_ctrl #(
      .TURNAROUND (T),
      .GAP_CYCLES (G)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_payload (cmd_payload),
      .SS_n        (SS_n),
      .MOSI        (MOSI),
      .MISO        (MISO),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [10:0] bits;
      int          len;
      bit          aborted;
   } frm_t;

   frm_t       fq[$];
   logic [7:0] rq[$];
   logic [7:0] mem[256];
   logic [7:0] waddr = 8'h00;
   logic [7:0] raddr = 8'h00;
   logic [7:0] miso_byte = 8'h00;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   // Present one command; the model is updated at the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [7:0] pl, input bit hold, output int acc);
      frm_t f;
      acc         = -1;
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_payload = pl;
      for (int i = 0; i < 200; i++) begin
         if (cmd_ready === 1'b1) begin
            acc = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) begin
         chk("accept_timeout", 32'd0, 32'd1);
         cmd_valid = 1'b0;
      end else begin
         f.bits    = {op[1], op, (op == 2'b11) ? 8'h00 : pl};
         f.len     = (op == 2'b11) ? 11 + T + 8 : 11;
         f.aborted = 1'b0;
         fq.push_back(f);
         case (op)
            2'b00: waddr = pl;
            2'b01: mem[waddr] = pl;
            2'b10: raddr = pl;
            default: begin
               miso_byte = mem[raddr];
               rq.push_back(mem[raddr]);
            end
         endcase
         @(negedge clk);
         if (!hold) cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (cmd_ready === 1'b1 && busy === 1'b0) return;
         @(negedge clk);
      end
      chk("idle_timeout", 32'd0, 32'd1);
   endtask

   // Slave model: replies MSB-first in frame cycles 12+T .. 19+T, junk elsewhere.
   initial begin
      int fc;
      fc   = 0;
      MISO = 1'b0;
      forever begin
         @(negedge clk);
         if (SS_n === 1'b0) fc++;
         else fc = 0;
         if (fc >= 12 + int'(T) && fc <= 19 + int'(T)) MISO = miso_byte[19 + int'(T) - fc];
         else MISO = 1'($urandom);
      end
   end

   // Monitor: checks frames on SS_n rise and read replies on rd_valid.
   initial begin
      int          run, hi_run;
      bit          tail_err, seen, prev_ss;
      logic [10:0] got;
      frm_t        f;
      run = 0; hi_run = 0; tail_err = 0; seen = 0; prev_ss = 1'b1; got = '0;
      forever begin
         @(negedge clk);
         if (SS_n === 1'b0) begin
            if (run == 0 && seen) chk("ss_gap", 32'(hi_run >= int'(G) + 1), 32'd1);
            if (run < 11) got[10 - run] = MOSI;
            else if (MOSI !== 1'b0) tail_err = 1'b1;
            chk("ready_in_frame", 32'(cmd_ready), 32'd0);
            chk("busy_in_frame", 32'(busy), 32'd1);
            run++;
            hi_run = 0;
         end else begin
            if (run > 0) begin
               seen = 1'b1;
               if (fq.size() == 0) begin
                  chk("unexpected_frame", 32'(run), 32'd0);
               end else begin
                  f = fq.pop_front();
                  if (!f.aborted) begin
                     chk("frame_bits", 32'(got), 32'(f.bits));
                     chk("frame_len", 32'(run), 32'(f.len));
                     chk("mosi_tail", 32'(tail_err), 32'd0);
                  end
               end
               run = 0;
               tail_err = 1'b0;
            end
            if (MOSI !== 1'b0) chk("mosi_idle", 32'(MOSI), 32'd0);
            hi_run++;
         end
         if (rd_valid === 1'b1) begin
            chk("rd_valid_pos", 32'(prev_ss == 1'b0 && SS_n === 1'b1), 32'd1);
            if (rq.size() == 0) chk("unexpected_rd", 32'(rd_data), 32'hFFFF);
            else chk("rd_data", 32'(rd_data), 32'(rq.pop_front()));
         end
         prev_ss = SS_n;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, a;
      logic [1:0] op;
      bit hold;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_payload = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_ss_n", 32'(SS_n), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_ss_n", 32'(SS_n), 32'd1);
      chk("post_rst_mosi", 32'(MOSI), 32'd0);
      chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("post_rst_rd_data", 32'(rd_data), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      issue(2'b00, 8'hA5, 1'b0, a);
      wait_idle();

      issue(2'b00, 8'h3C, 1'b0, a); wait_idle();
      issue(2'b01, 8'h96, 1'b0, a); wait_idle();
      issue(2'b10, 8'h3C, 1'b0, a); wait_idle();
      issue(2'b11, 8'h5E, 1'b0, a); wait_idle();

      mem[raddr] = 8'hC3;
      issue(2'b11, 8'h00, 1'b0, a); wait_idle();

      issue(2'b00, 8'($urandom), 1'b1, a1);
      issue(2'b01, 8'($urandom), 1'b0, a2);
      chk("b2b_spacing", 32'(a2 - a1), 32'(11 + G + 1));
      wait_idle();

      // Abort a read in its 4th capture cycle.
      mem[raddr] = 8'hE7;
      issue(2'b11, 8'h00, 1'b0, a);
      fq[fq.size() - 1].aborted = 1'b1;
      void'(rq.pop_back());
      while (cyc < a + int'(T) + 14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ss_n", 32'(SS_n), 32'd1);
      chk("abort_mosi", 32'(MOSI), 32'd0);
      chk("abort_rd_valid", 32'(rd_valid), 32'd0);
      chk("abort_rd_data", 32'(rd_data), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      issue(2'b00, 8'h5A, 1'b0, a);
      wait_idle();

      for (int n = 0; n < 40; n++) begin
         op   = 2'($urandom_range(0, 3));
         hold = (n != 39) && ($urandom_range(0, 3) == 0);
         issue(op, 8'($urandom), hold, a);
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      repeat (5) @(negedge clk);
      chk("frames_drained", 32'(fq.size()), 32'd0);
      chk("reads_drained", 32'(rq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Initiator side of the SPI slave / single-port RAM link. Converts parallel commands (write address, write data, read address, read data) into serial SS_n/MOSI frames.
- For read-data commands, captures the 8-bit MISO reply and returns it on a parallel response port.
- Sits between the bench or host sequencer and the SPI slave. Shares the slave's clock, which serves as SCK.

Parameters:
- TURNAROUND, 2, number of idle cycles after the 11th MOSI bit of a read-data frame before the first MISO sample; legal range 1..15.
- GAP_CYCLES, 1, number of cycles SS_n is held high after every frame before the next command is accepted; legal range 1..15.

Ports:
- clk  input  1  system clock; also the SPI bit clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 write address, 01 write data, 10 read address, 11 read data.
- cmd_payload  input  8  address or write data; ignored for op 11.
- SS_n  output  1  slave select, active low.
- MOSI  output  1  serial data to the slave.
- MISO  input  1  serial data from the slave.
- rd_valid  output  1  one-cycle pulse: rd_data is valid.
- rd_data  output  8  byte captured from MISO.
- busy  output  1  high from command acceptance until the return to IDLE.

Behaviour:
- Reset values: SS_n=1, MOSI=0, cmd_ready=0 while rst is high, rd_valid=0, rd_data=8'h00, busy=0, state=IDLE. cmd_ready rises in the first cycle after rst deasserts.
- Handshake: a command is accepted on a clk edge with cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. op and payload are latched into a 10-bit frame register {op, payload}. For op 11 the payload field is 8'h00.
- States: IDLE -> CMD -> SHIFT -> (TURN -> CAPTURE) -> END -> IDLE.
- IDLE: SS_n=1, MOSI=0. On acceptance, go to CMD.
- CMD: exactly 1 cycle. SS_n=0, MOSI=op[1] (the slave's command-check bit). Go to SHIFT.
- SHIFT: exactly 10 cycles. MOSI = frame[9] down to frame[0], MSB first. A 4-bit counter counts 0..9. After the 10th bit, go to TURN if op==11, else go to END.
- TURN: exactly TURNAROUND cycles. SS_n=0, MOSI=0, MISO ignored.
- CAPTURE: exactly 8 cycles. SS_n=0, MOSI=0. MISO is shifted into rd_data on each clk edge, MSB first (first sampled bit becomes rd_data[7]).
- END: lasts GAP_CYCLES cycles. SS_n=1, MOSI=0. In the first END cycle of a read-data frame, rd_valid=1 and rd_data holds the captured byte. rd_data keeps its value until the next capture completes.
- Frame lengths with SS_n low:
  - ops 00/01/10: 11 cycles.
  - op 11: 11+TURNAROUND+8 cycles.
- busy = (state != IDLE).
- cmd_valid held high during a frame is ignored. No command is queued; the next command is accepted only in IDLE.
- Back-to-back commands: command acceptance is at least 11+GAP_CYCLES+1 cycles apart for writes, and SS_n is never low across two frames.
- The controller does not track whether a read address was sent. Issuing op 11 without a prior op 10 is legal at this block; the slave defines the result.
- rst asserted mid-frame: at the next edge, SS_n=1, MOSI=0, rd_valid=0, counters cleared, state=IDLE. A partial rd_data capture is discarded and rd_data resets to 8'h00.
- rst has priority over a simultaneous cmd_valid.

Decomposition:
- shared_pkg additions:
  - Master state encodings M_IDLE=3'b000, M_CMD=3'b001, M_SHIFT=3'b010, M_TURN=3'b011, M_CAPTURE=3'b100, M_END=3'b101.
  - Op encodings OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - FRAME_BITS=10 and RD_BITS=8, alongside the existing ADDR_SIZE and MEM_WIDTH.
- One sub-module: spi_mst_shift_reg, a parameterised load/shift register with serial-in and serial-out, instantiated once for the TX frame and once for the RX byte.

Test Plan:
- Reset then idle: hold rst 3 cycles, then release -> SS_n=1, MOSI=0, rd_valid=0, rd_data=8'h00, and cmd_ready=1 one cycle after release.
- Write address: op=00, payload=8'hA5 -> SS_n low exactly 11 cycles; MOSI sequence 0,0,0,1,0,1,0,0,1,0,1; then SS_n=1 for GAP_CYCLES; rd_valid never pulses.
- Write then read-back with the slave connected: op00 8'h3C, then op01 8'h96, then op10 8'h3C, then op11 -> rd_valid pulses once with rd_data=8'h96. For op10, MOSI bits 1,1,0 lead the frame.
- Read-data capture with a modelled MISO: TURNAROUND=2 and MISO driving 8'hC3 MSB-first from cycle 14 of the frame -> rd_data=8'hC3 and rd_valid is high in exactly one cycle, at the first SS_n-high cycle.
- Back-to-back plus ignored valid: cmd_valid held high with two queued writes -> second acceptance occurs exactly 11+GAP_CYCLES+1 cycles after the first; cmd_ready=0 throughout the frame; SS_n shows a high gap.
- Reset mid-read: assert rst during the 4th CAPTURE cycle -> next edge SS_n=1, rd_valid=0, rd_data=8'h00; a subsequent op00 completes normally.
